// File: rtl/gate_checker_pkg.sv
// Shared types and constants for the two-input gate response checker.
package gate_checker_pkg;

  localparam int unsigned VEC_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  // One observed sample, packed as {I0,I1,Out}
  typedef struct packed {
    logic i0;
    logic i1;
    logic out;
  } vec_t;

  // Bit n is the expected output for input combination n = {I0,I1}
  localparam logic [3:0] TT_NOR  = 4'b0001;
  localparam logic [3:0] TT_OR   = 4'b1110;
  localparam logic [3:0] TT_AND  = 4'b1000;
  localparam logic [3:0] TT_NAND = 4'b0111;
  localparam logic [3:0] TT_XOR  = 4'b0110;
  localparam logic [3:0] TT_XNOR = 4'b1001;

  function automatic logic [1:0] combo_idx(input vec_t v);
    return {v.i0, v.i1};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Parameterized-width saturating up-counter with synchronous clear.
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/gate_checker.sv
// Gate response checker: two-stage sample/compare pipeline, coverage, error stats.
// Optional build macro GATE_CHECKER_STOP_ON_ERR_EN: first mismatch ends checking in FAIL.
module gate_checker
  import gate_checker_pkg::*;
#(
  parameter logic [3:0]  TRUTH_TABLE = TT_NOR,
  parameter int unsigned ERR_CNT_W   = 8
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN,
  input  logic                 CLR,
  input  logic                 VALID,
  input  logic                 I0,
  input  logic                 I1,
  input  logic                 Out,
  output logic                 MISMATCH,
  output logic [ERR_CNT_W-1:0] ERR_CNT,
  output logic [3:0]           COVERED,
  output logic                 DONE,
  output logic                 PASS,
  output logic [VEC_W-1:0]     FIRST_ERR,
  output logic                 FIRST_ERR_VLD
);

  state_e state_q, state_d;
  logic   s1_vld_q;
  vec_t   s1_vec_q;
  logic   accept_c;
  logic   mis_c;
  logic   done_d;
  logic   pass_d;

  assign accept_c = VALID && (state_q == ST_CHECK) && !CLR;
  assign mis_c    = s1_vld_q && (s1_vec_q.out != TRUTH_TABLE[combo_idx(s1_vec_q)]);

  always_ff @(posedge CLK) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next state; coverage completion is judged on the registered COVERED
  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    pass_d  = 1'b0;
    case (state_q)
      ST_IDLE:  if (EN) state_d = ST_CHECK;
      ST_CHECK: begin
        if (COVERED == 4'hF) state_d = ST_DONE;
        else if (!EN)        state_d = ST_IDLE;
`ifdef GATE_CHECKER_STOP_ON_ERR_EN
        if (mis_c) state_d = ST_FAIL;
`endif
      end
      ST_DONE:  state_d = ST_DONE;
      ST_FAIL:  state_d = ST_FAIL;
      default:  state_d = ST_IDLE;
    endcase
    if (CLR) state_d = ST_IDLE;
    done_d = (state_d == ST_DONE) || (state_d == ST_FAIL);
    pass_d = done_d && (ERR_CNT == '0) && !mis_c;
  end

  // Stage 1 capture, stage 2 compare results and sticky statistics
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      s1_vld_q      <= 1'b0;
      s1_vec_q      <= '0;
      MISMATCH      <= 1'b0;
      COVERED       <= '0;
      FIRST_ERR     <= '0;
      FIRST_ERR_VLD <= 1'b0;
      DONE          <= 1'b0;
      PASS          <= 1'b0;
    end else begin
      s1_vld_q <= accept_c;
      if (accept_c) s1_vec_q <= '{i0: I0, i1: I1, out: Out};
      MISMATCH <= mis_c;
      if (s1_vld_q) COVERED[combo_idx(s1_vec_q)] <= 1'b1;
      if (mis_c && !FIRST_ERR_VLD) begin
        FIRST_ERR     <= s1_vec_q;
        FIRST_ERR_VLD <= 1'b1;
      end
      DONE <= done_d;
      PASS <= pass_d;
    end
  end

  sat_counter #(
    .W(ERR_CNT_W)
  ) u_err_cnt (
    .clk(CLK),
    .rst(RST),
    .clr(CLR),
    .inc(mis_c),
    .cnt(ERR_CNT)
  );

endmodule

// File: tb/tb_gate_checker.sv
// Scoreboard bench for gate_checker (default NOR table, 8-bit error counter).
module tb_gate_checker;
  import gate_checker_pkg::*;

  typedef struct {
    int         due;
    logic       mis;
    logic [7:0] cnt;
    logic [3:0] cov;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST, EN, CLR, VALID, I0, I1, Out;
  logic       MISMATCH, DONE, PASS, FIRST_ERR_VLD;
  logic [7:0] ERR_CNT;
  logic [3:0] COVERED;
  logic [2:0] FIRST_ERR;

  exp_t       sb[$];
  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;
  logic [3:0] tt     = TT_NOR;
  logic [3:0] m_cov;
  logic [7:0] m_cnt;

  gate_checker #(.TRUTH_TABLE(TT_NOR), .ERR_CNT_W(8)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CLR(CLR), .VALID(VALID),
    .I0(I0), .I1(I1), .Out(Out),
    .MISMATCH(MISMATCH), .ERR_CNT(ERR_CNT), .COVERED(COVERED),
    .DONE(DONE), .PASS(PASS), .FIRST_ERR(FIRST_ERR), .FIRST_ERR_VLD(FIRST_ERR_VLD)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  // Advance one edge, then compare any scoreboard entry due at this edge
  task automatic tick();
    exp_t e;
    @(posedge CLK);
    cyc++;
    #1;
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("mismatch", 32'(MISMATCH), 32'(e.mis));
      check("err_cnt", 32'(ERR_CNT), 32'(e.cnt));
      check("covered", 32'(COVERED), 32'(e.cov));
    end else begin
      check("mismatch_idle", 32'(MISMATCH), 32'd0);
    end
  endtask

  task automatic send(input logic a, input logic b, input logic o, input bit acc);
    logic [1:0] idx;
    logic       mis;
    idx   = {a, b};
    I0    = a;
    I1    = b;
    Out   = o;
    VALID = 1'b1;
    if (acc) begin
      mis = (o != tt[idx]);
      if (mis && m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
      m_cov[idx] = 1'b1;
      sb.push_back('{cyc + 2, mis, m_cnt, m_cov});
    end
    tick();
    VALID = 1'b0;
  endtask

  task automatic check_clear(input string tag);
    check({tag, "_cnt"}, 32'(ERR_CNT), 32'd0);
    check({tag, "_cov"}, 32'(COVERED), 32'd0);
    check({tag, "_fev"}, 32'(FIRST_ERR_VLD), 32'd0);
    check({tag, "_fe"}, 32'(FIRST_ERR), 32'd0);
    check({tag, "_done"}, 32'(DONE), 32'd0);
    check({tag, "_pass"}, 32'(PASS), 32'd0);
  endtask

  // Clear statistics and return to CHECK (EN must already be high)
  task automatic restart();
    CLR = 1'b1;
    sb.delete();
    tick();
    CLR   = 1'b0;
    m_cov = '0;
    m_cnt = '0;
    check_clear("clr");
    tick();
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; CLR = 1'b0; VALID = 1'b0; I0 = 1'b0; I1 = 1'b0; Out = 1'b0;
    m_cov = '0;
    m_cnt = '0;
    tick();
    tick();
    RST = 1'b0;
    check_clear("reset");
    check("reset_mis", 32'(MISMATCH), 32'd0);

    // Correct NOR gate over all combinations
    EN = 1'b1;
    tick();
    send(1'b0, 1'b0, 1'b1, 1'b1);
    send(1'b0, 1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    check("cov_full_done_lag", 32'(DONE), 32'd0);
    tick();
    check("ok_done", 32'(DONE), 32'd1);
    check("ok_pass", 32'(PASS), 32'd1);
    check("ok_fev", 32'(FIRST_ERR_VLD), 32'd0);

    // Wrong output on 11
    restart();
    send(1'b0, 1'b0, 1'b1, 1'b1);
    send(1'b0, 1'b1, 1'b0, 1'b1);
    send(1'b1, 1'b0, 1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    check("bad11_done", 32'(DONE), 32'd1);
    check("bad11_pass", 32'(PASS), 32'd0);
    check("bad11_fe", 32'(FIRST_ERR), 32'b111);
    check("bad11_fev", 32'(FIRST_ERR_VLD), 32'd1);

`ifndef GATE_CHECKER_STOP_ON_ERR_EN
    // Saturation of the error counter
    restart();
    for (int i = 0; i < 300; i++) send(1'b1, 1'b1, 1'b1, 1'b1);
    tick();
    tick();
    check("sat_cnt", 32'(ERR_CNT), 32'd255);
    check("sat_done", 32'(DONE), 32'd0);
`endif

    // CLR together with VALID mid-run; later VALID while IDLE is ignored
    restart();
    send(1'b0, 1'b0, 1'b1, 1'b1);
    send(1'b0, 1'b1, 1'b1, 1'b1);
    CLR = 1'b1; EN = 1'b0; VALID = 1'b1; I0 = 1'b1; I1 = 1'b0; Out = 1'b0;
    sb.delete();
    tick();
    CLR = 1'b0; VALID = 1'b0;
    m_cov = '0;
    m_cnt = '0;
    check_clear("clr_valid");
    send(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    check_clear("idle_ignore");

    // Pause after two combinations, then resume
    EN = 1'b1;
    restart();
    send(1'b0, 1'b0, 1'b1, 1'b1);
    send(1'b0, 1'b1, 1'b0, 1'b1);
    EN = 1'b0;
    tick();
    send(1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    tick();
    check("pause_cov", 32'(COVERED), 32'b0011);
    check("pause_done", 32'(DONE), 32'd0);
    EN = 1'b1;
    tick();
    send(1'b1, 1'b0, 1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b0, 1'b1);
    tick();
    tick();
    check("resume_done", 32'(DONE), 32'd1);
    check("resume_pass", 32'(PASS), 32'd1);

`ifdef GATE_CHECKER_STOP_ON_ERR_EN
    // Mismatch on 01 stops checking; in-flight sample completes, later ones dropped
    restart();
    send(1'b0, 1'b0, 1'b1, 1'b1);
    send(1'b0, 1'b1, 1'b1, 1'b1);
    send(1'b1, 1'b0, 1'b0, 1'b1);
    send(1'b1, 1'b1, 1'b0, 1'b0);
    send(1'b1, 1'b1, 1'b1, 1'b0);
    tick();
    tick();
    check("stop_cov", 32'(COVERED), 32'b0111);
    check("stop_cnt", 32'(ERR_CNT), 32'd1);
    check("stop_done", 32'(DONE), 32'd1);
    check("stop_pass", 32'(PASS), 32'd0);
    check("stop_fe", 32'(FIRST_ERR), 32'b011);
`endif

    // Reset mid-operation discards all state
    restart();
    send(1'b0, 1'b0, 1'b0, 1'b1);
    RST = 1'b1;
    sb.delete();
    tick();
    RST = 1'b0;
    check_clear("rst_mid");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/gate_checker.md
# gate_checker

Synthesizable response checker for two-input basic gates: it sits at the output end of the gate stimulus path and observes the gate's inputs and output. Each strobed sample is compared against a parameterized truth table. The block tracks which of the four input combinations have been exercised, counts mismatches, and captures the first failing vector. It raises DONE/PASS once all combinations are covered.

## Interface
- TRUTH_TABLE, 4'b0001, expected output indexed by {I0,I1}; bit n = expected Out for input n (default = NOR)
- ERR_CNT_W, 8, width of the mismatch counter
- CLK  in  1  rising-edge clock
- RST  in  1  synchronous, active-high reset
- EN  in  1  enables checking; low = IDLE
- CLR  in  1  one-cycle clear of statistics; returns FSM to IDLE
- VALID  in  1  sample strobe; I0/I1/Out are valid this cycle
- I0  in  1  gate input 0 as driven
- I1  in  1  gate input 1 as driven
- Out  in  1  gate output under check
- MISMATCH  out  1  one-cycle pulse per failing sample
- ERR_CNT  out  ERR_CNT_W  saturating mismatch count
- COVERED  out  4  bit n set once input combination n was sampled
- DONE  out  1  all four combinations covered, or FAIL reached
- PASS  out  1  DONE with ERR_CNT==0
- FIRST_ERR  out  3  {I0,I1,Out} of the first mismatch
- FIRST_ERR_VLD  out  1  FIRST_ERR holds a captured vector

## Operation
- Clock and reset: single clock CLK; reset RST is synchronous and active-high.
- FSM states: IDLE, CHECK, DONE, FAIL.
  - IDLE→CHECK when EN=1.
  - CHECK→DONE when COVERED becomes 4'hF.
  - CHECK→IDLE when EN=0; statistics are held, and re-enabling resumes accumulation.
  - DONE and FAIL hold until CLR or RST.
- Sampling:
  - Stage 1 registers {I0,I1,Out} on an edge where VALID=1 and the state is CHECK.
  - Stage 2 compares Out against TRUTH_TABLE[{I0,I1}], sets COVERED[{I0,I1}], and on mismatch pulses MISMATCH and increments ERR_CNT.
  - The first mismatch loads FIRST_ERR and sets FIRST_ERR_VLD; later mismatches do not overwrite it.
- VALID is ignored in IDLE, DONE and FAIL. A sample already in stage 1 still completes its compare.
- ERR_CNT saturates at 2^ERR_CNT_W-1 and does not wrap.
- CLR and VALID in the same cycle: CLR wins, the sample is dropped, and any stage-1 sample is flushed.
- CLR zeroes ERR_CNT, COVERED and FIRST_ERR/FIRST_ERR_VLD, deasserts DONE/PASS, and sets the FSM to IDLE.
- Reset values: every output is 0, FSM=IDLE, pipeline empty. RST mid-operation discards all state.

## Timing
- The sample is captured at edge k. MISMATCH, ERR_CNT, COVERED and FIRST_ERR update at edge k+1. Latency is 1 cycle after capture.
- DONE/PASS assert at edge k+2 after the edge-k capture of the covering sample, i.e. one cycle after COVERED reaches 4'hF.
- Back-to-back VALID is supported at one sample per cycle.
- MISMATCH is high for exactly one cycle per failing sample.

## Configuration
- GATE_CHECKER_STOP_ON_ERR_EN
  - Defined: the first mismatch moves CHECK→FAIL at the compare edge. DONE=1 and PASS=0 the next cycle. A stage-1 sample still completes and may raise ERR_CNT to 2; no further samples are accepted.
  - Undefined: the FAIL state is unreachable. Checking continues to full coverage, and PASS reflects ERR_CNT==0.

## Structure
- gate_checker_pkg holds:
  - FSM state typedef/encodings
  - truth-table constants (NOR, OR, AND, NAND, XOR, XNOR)
  - the width of the {I0,I1,Out} vector
- Sub-module sat_counter: a parameterized-width saturating incrementer with synchronous clear, instantiated for ERR_CNT.

## Test plan
- Default NOR table, EN=1, VALID on 00/01/10/11 with a correct gate → COVERED=4'hF, ERR_CNT=0, DONE=1, PASS=1.
- Out forced to 1 on input 11 → single MISMATCH pulse, ERR_CNT=1, FIRST_ERR=3'b111, PASS=0 after coverage.
- 300 failing samples with ERR_CNT_W=8 → ERR_CNT stops at 255.
- CLR asserted with VALID in the same cycle mid-run → all statistics 0, FSM IDLE, sample not counted.
- EN dropped after 2 combinations, then reasserted for the remaining 2 → COVERED=4'hF, DONE=1.
- With GATE_CHECKER_STOP_ON_ERR_EN, a mismatch on 01 followed by valid samples → FAIL, DONE=1, PASS=0, later samples ignored.
